uart_tx: RTL and testbench

Memory-mapped UART transmitter; the send-side counterpart of the UART receive path feeding the `in_uart`/`uart_new_data` words in data memory. It takes a byte and a send strobe from the memory block's `out_uart`/`send_uart` words and queues the byte in a small FIFO. It serializes each byte as 8N1, LSB first, at a fixed baud divisor. Busy/full/overflow status is exposed so the CPU can poll it through a memory-mapped status word.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default baud divisor and the
// memory-map word addresses used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // 50 MHz system clock at 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [7:0] ADDR_IN_UART       = 8'hF0;
  localparam logic [7:0] ADDR_UART_NEW_DATA = 8'hF1;
  localparam logic [7:0] ADDR_OUT_UART      = 8'hF2;
  localparam logic [7:0] ADDR_SEND_UART     = 8'hF3;
  localparam logic [7:0] ADDR_UART_STATUS   = 8'hF4;

  localparam int unsigned STATUS_BUSY_BIT     = 0;
  localparam int unsigned STATUS_FULL_BIT     = 1;
  localparam int unsigned STATUS_OVERFLOW_BIT = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue between the CPU send strobe and the serializer: count-based
// full/empty, first-word-fall-through read, push+pop legal at any occupancy.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full queue is kept
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: send-strobe edge detect, byte FIFO,
// and a start/data/stop serializer running at a fixed baud divisor.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] out_uart,
  input  logic       send_uart,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             send_prev_q;
  logic             overflow_q, overflow_d;

  logic             req;
  logic             baud_done;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full_w;
  logic [7:0]       fifo_rdata;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req),
    .pop   (fifo_pop),
    .wdata (out_uart),
    .rdata (fifo_rdata),
    .full  (fifo_full_w),
    .empty (fifo_empty)
  );

  assign req        = send_uart & ~send_prev_q;
  assign baud_done  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign overflow_d = overflow_q | (req & fifo_full_w & ~fifo_pop);

  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
  assign fifo_full = fifo_full_w;
  assign overflow  = overflow_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          tx_d     = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          cnt_d     = '0;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more bytes are waiting
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            tx_d     = 1'b0;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      send_prev_q <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      send_prev_q <= send_uart;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a serial-line
// monitor decodes 8N1 frames from tx and checks them against the queue.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] out_uart;
  logic       send_uart;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         starts_q[$];

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .out_uart  (out_uart),
    .send_uart (send_uart),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial-line monitor: decodes frames purely from the tx waveform
  int         cyc = 0;
  bit         in_frame = 1'b0;
  int         pos;
  bit         frame_ok;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    int slot;
    logic [7:0] e;
    cyc++;
    if (rst === 1'b1) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        pos      = 1;
        frame_ok = 1'b1;
        rx_byte  = 8'h00;
        starts_q.push_back(cyc);
      end
    end else begin
      slot = pos / CPB;
      if (slot == 0) begin
        if (tx !== 1'b0) frame_ok = 1'b0;
      end else if (slot <= 8) begin
        if (pos % CPB == 0) rx_byte[slot-1] = tx;
        else if (tx !== rx_byte[slot-1]) frame_ok = 1'b0;
      end else begin
        if (tx !== 1'b1) frame_ok = 1'b0;
      end
      pos++;
      if (pos == FRAME) begin
        in_frame = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: got byte %0h expected no frame", rx_byte);
        end else begin
          e = exp_q.pop_front();
          if (!frame_ok || rx_byte !== e) begin
            errors++;
            $display("FAIL frame_data: got %0h (framing_ok=%0d) expected %0h", rx_byte, frame_ok, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    out_uart  = b;
    send_uart = 1'b1;
    step();
    send_uart = 1'b0;
    step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n >= 2000), 0);
    repeat (2) @(negedge clk);
    chk("all_frames_seen", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int lows;
    logic [7:0] b;

    rst       = 1'b1;
    send_uart = 1'b0;
    out_uart  = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    step();

    // Single byte with latency and busy duration
    out_uart  = 8'h55;
    send_uart = 1'b1;
    exp_q.push_back(8'h55);
    @(posedge clk);
    @(negedge clk);
    chk("single_busy_rise", busy, 1);
    chk("single_tx_before_start", tx, 1);
    send_uart = 1'b0;
    @(negedge clk);
    chk("single_tx_start", tx, 0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("single_busy_len", n, 40);
    repeat (5) @(negedge clk);
    chk("single_tx_idle", tx, 1);
    chk("single_done", exp_q.size(), 0);
    step();

    // Back-to-back frames must be contiguous
    starts_q.delete();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    wait_idle();
    chk("b2b_frames", starts_q.size(), 2);
    if (starts_q.size() == 2) chk("b2b_gap", starts_q[1] - starts_q[0], FRAME);
    step();

    // Overflow: six requests, the sixth is dropped
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i));
    end
    chk("ovf_full", fifo_full, 1);
    chk("ovf_not_yet", overflow, 0);
    send_byte(8'h06);
    chk("ovf_set", overflow, 1);
    wait_idle();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_full_clear", fifo_full, 0);
    do_reset();
    chk("ovf_rst_clear", overflow, 0);

    // Level hold sends one byte
    out_uart  = 8'h7E;
    send_uart = 1'b1;
    exp_q.push_back(8'h7E);
    repeat (100) step();
    send_uart = 1'b0;
    wait_idle();

    // Reset mid-frame aborts frame and discards queue
    send_byte(8'hFF);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (11) step();
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_full", fifo_full, 0);
    rst = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("midrst_no_frames", lows, 0);
    step();

    // send_uart held through reset release
    out_uart  = 8'h42;
    send_uart = 1'b1;
    rst       = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("held_no_send", lows, 0);
    step();
    send_uart = 1'b0;
    step();
    exp_q.push_back(8'h96);
    send_byte(8'h96);
    wait_idle();

    // Randomized bursts from idle: first DEPTH+1 accepted, rest dropped
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        if (i < DEPTH + 1) exp_q.push_back(b);
        send_byte(b);
        repeat ($urandom_range(0, 2)) step();
      end
      chk("rand_overflow", overflow, (n > DEPTH + 1));
      wait_idle();
      if (overflow === 1'b1) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
